// File: rtl/adpll_pkg.sv
// Shared ADPLL definitions: phase-error width and lock-detector state codes.
package adpll_pkg;

    localparam int ERR_W = 5;

    typedef enum logic [1:0] {
        LD_UNLOCKED  = 2'd0,
        LD_ACQUIRING = 2'd1,
        LD_LOCKED    = 2'd2,
        LD_LOSING    = 2'd3
    } ld_state_t;

endpackage

// File: rtl/adpll_sat_counter.sv
// Saturating up-counter with synchronous active-low reset and clear.
// Asserting clr together with inc restarts the count at 1.
module adpll_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         sat
);

    assign sat = &count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? W'(1) : '0;
        end else if (inc && !sat) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/adpll_lock_detect_5bit.sv
// ADPLL lock detector: qualifies lock on the 5-bit phase error with hysteresis.
// Optional lock-loss statistics counter enabled by ADPLL_LOCK_STATS_EN.
module adpll_lock_detect_5bit
    import adpll_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int STAT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_en,
    input  logic [ERR_W-1:0]  error,
    input  logic              error_sign,
    input  logic [ERR_W-1:0]  lock_thresh,
    input  logic [CNT_W-1:0]  lock_cnt,
    input  logic [CNT_W-1:0]  unlock_cnt,
    output logic              locked,
    output logic [1:0]        lock_state,
    output logic              lock_lost,
    output logic [STAT_W-1:0] lost_events
);

    // sample_en is a one-cycle strobe with no backpressure: every cycle it is
    // high, the error is consumed and the registered outputs update next clk.
    ld_state_t          state, state_nx;
    logic [CNT_W-1:0]   run_cnt;
    logic [CNT_W-1:0]   eff_lock, eff_unlock;
    logic [CNT_W:0]     run_inc;
    logic               in_band;
    logic               cnt_inc, cnt_clr, lost_nx;
    logic               run_sat_unused;
    logic               sign_unused;

    // Sign only matters to the loop filter; lock is judged on magnitude.
    assign sign_unused = error_sign;

    assign in_band    = (error <= lock_thresh);
    assign eff_lock   = (lock_cnt   == '0) ? CNT_W'(1) : lock_cnt;
    assign eff_unlock = (unlock_cnt == '0) ? CNT_W'(1) : unlock_cnt;
    assign run_inc    = {1'b0, run_cnt} + (CNT_W+1)'(1);
    assign lock_state = state;

    always_comb begin
        state_nx = state;
        cnt_inc  = 1'b0;
        cnt_clr  = 1'b0;
        lost_nx  = 1'b0;
        if (sample_en) begin
            case (state)
                LD_UNLOCKED: begin
                    cnt_clr = 1'b1;
                    if (in_band) begin
                        if (eff_lock == CNT_W'(1)) begin
                            state_nx = LD_LOCKED;
                        end else begin
                            cnt_inc  = 1'b1;
                            state_nx = LD_ACQUIRING;
                        end
                    end
                end
                LD_ACQUIRING: begin
                    if (!in_band) begin
                        cnt_clr  = 1'b1;
                        state_nx = LD_UNLOCKED;
                    end else if (run_inc >= {1'b0, eff_lock}) begin
                        cnt_clr  = 1'b1;
                        state_nx = LD_LOCKED;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                LD_LOCKED: begin
                    cnt_clr = 1'b1;
                    if (!in_band) begin
                        if (eff_unlock == CNT_W'(1)) begin
                            lost_nx  = 1'b1;
                            state_nx = LD_UNLOCKED;
                        end else begin
                            cnt_inc  = 1'b1;
                            state_nx = LD_LOSING;
                        end
                    end
                end
                LD_LOSING: begin
                    if (in_band) begin
                        cnt_clr  = 1'b1;
                        state_nx = LD_LOCKED;
                    end else if (run_inc >= {1'b0, eff_unlock}) begin
                        cnt_clr  = 1'b1;
                        lost_nx  = 1'b1;
                        state_nx = LD_UNLOCKED;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                default: begin
                    cnt_clr  = 1'b1;
                    state_nx = LD_UNLOCKED;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= LD_UNLOCKED;
            locked    <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state     <= state_nx;
            locked    <= (state_nx == LD_LOCKED) || (state_nx == LD_LOSING);
            lock_lost <= lost_nx;
        end
    end

    adpll_sat_counter #(.W(CNT_W)) u_run_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .count (run_cnt),
        .sat   (run_sat_unused)
    );

`ifdef ADPLL_LOCK_STATS_EN
    logic stats_sat_unused;

    // Counts on the same edge that raises lock_lost, so both move together.
    adpll_sat_counter #(.W(STAT_W)) u_lost_events (
        .clk   (clk),
        .reset (reset),
        .inc   (lost_nx),
        .clr   (1'b0),
        .count (lost_events),
        .sat   (stats_sat_unused)
    );
`else
    assign lost_events = '0;
`endif

endmodule
